// File: rtl/lock_pkg.sv
// Shared types and defaults for locked-IP key loaders.
package lock_pkg;

  localparam int KEY_WIDTH_DEF = 29;
  localparam int MAX_FAILS_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    PARITY,
    COMMIT,
    LOCKED,
    ERROR,
    DEAD
  } state_t;

  typedef logic [KEY_WIDTH_DEF-1:0] key_t;

endpackage

// File: rtl/lock_key_loader_if.sv
// Serial key-bit valid/ready link between the key store and the loader.
interface lock_key_loader_if;

  logic sdi_valid;
  logic sdi_data;
  logic sdi_ready;

  modport master (output sdi_valid, output sdi_data, input sdi_ready);
  modport slave  (input sdi_valid, input sdi_data, output sdi_ready);

endinterface

// File: rtl/lock_fail_counter.sv
// Saturating failed-attempt counter. near_limit flags that one more
// increment reaches MAX_FAILS, so the caller can branch in the same cycle.
module lock_fail_counter #(
  parameter int MAX_FAILS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit,
  output logic near_limit
);

  localparam int CW = $clog2(MAX_FAILS + 1);

  logic [CW-1:0] r_count;

  assign at_limit   = (r_count == CW'(MAX_FAILS));
  assign near_limit = (r_count == CW'(MAX_FAILS - 1));

  // Count failures, saturating at the limit; clr restarts the tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !at_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/lock_key_loader.sv
// Bit-serial key loader: shifts in the key, checks even parity, commits it
// to a held parallel register driving the locked core's key pins.
module lock_key_loader
  import lock_pkg::*;
#(
  parameter int KEY_WIDTH = KEY_WIDTH_DEF,
  parameter int MAX_FAILS = MAX_FAILS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 zeroize,
  lock_key_loader_if.slave     sdi,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 err,
  output logic                 dead
);

  localparam int CW = $clog2(KEY_WIDTH);

  state_t               r_state, w_state_next;
  logic [KEY_WIDTH-1:0] r_shadow, w_shadow_next;
  logic [KEY_WIDTH-1:0] r_key_out, w_key_out_next;
  logic [CW-1:0]        r_count, w_count_next;
  logic                 r_key_valid, w_key_valid_next;
  logic                 r_busy, r_err, r_dead;
  logic                 w_xfer, w_fail_inc, w_fail_clr;
  logic                 w_at_limit, w_near_limit;

  // Ready is a pure state decode so the sender never sees an input loop.
  assign sdi.sdi_ready = (r_state == SHIFT) || (r_state == PARITY);
  assign w_xfer        = sdi.sdi_valid && sdi.sdi_ready;

  assign key_out   = r_key_out;
  assign key_valid = r_key_valid;
  assign busy      = r_busy;
  assign err       = r_err;
  assign dead      = r_dead;

  lock_fail_counter #(.MAX_FAILS(MAX_FAILS)) u_fail_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (w_fail_clr),
    .inc        (w_fail_inc),
    .at_limit   (w_at_limit),
    .near_limit (w_near_limit)
  );

  // Next-state, shadow, key and attempt-counter control.
  always_comb begin
    w_state_next     = r_state;
    w_shadow_next    = r_shadow;
    w_count_next     = r_count;
    w_key_out_next   = r_key_out;
    w_key_valid_next = r_key_valid;
    w_fail_inc       = 1'b0;
    w_fail_clr       = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next  = SHIFT;
          w_count_next  = '0;
          w_shadow_next = '0;
        end
      end
      SHIFT: begin
        if (w_xfer) begin
          w_shadow_next[r_count] = sdi.sdi_data;
          if (r_count == CW'(KEY_WIDTH - 1)) begin
            w_state_next = PARITY;
          end else begin
            w_count_next = r_count + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_xfer) begin
          if (((^r_shadow) ^ sdi.sdi_data) == 1'b0) begin
            w_state_next = COMMIT;
          end else begin
            w_fail_inc = 1'b1;
            if (w_near_limit || w_at_limit) begin
              w_state_next     = DEAD;
              w_key_out_next   = '0;
              w_key_valid_next = 1'b0;
            end else begin
              w_state_next = ERROR;
            end
          end
        end
      end
      COMMIT: begin
        w_key_out_next   = r_shadow;
        w_key_valid_next = 1'b1;
        w_state_next     = LOCKED;
        w_fail_clr       = 1'b1;
      end
      LOCKED: begin
        w_state_next = LOCKED;
      end
      ERROR: begin
        w_shadow_next = '0;
        if (start) begin
          w_state_next = SHIFT;
          w_count_next = '0;
        end
      end
      DEAD: begin
        w_key_out_next   = '0;
        w_key_valid_next = 1'b0;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Zeroize overrides everything except the permanent lockout; the
    // attempt counter is deliberately left untouched.
    if (zeroize && (r_state != DEAD)) begin
      w_state_next     = IDLE;
      w_shadow_next    = '0;
      w_key_out_next   = '0;
      w_key_valid_next = 1'b0;
      w_count_next     = '0;
      w_fail_inc       = 1'b0;
      w_fail_clr       = 1'b0;
    end
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shadow    <= '0;
      r_key_out   <= '0;
      r_count     <= '0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_dead      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shadow    <= w_shadow_next;
      r_key_out   <= w_key_out_next;
      r_count     <= w_count_next;
      r_key_valid <= w_key_valid_next;
      r_busy      <= (w_state_next == SHIFT) || (w_state_next == PARITY);
      r_err       <= (w_state_next == ERROR);
      r_dead      <= (w_state_next == DEAD);
    end
  end

endmodule
